regfile_32x64: RTL

- LEGv8 integer register file: 32 x 64-bit architectural registers X0-X31, one write port, two read ports.
- Feeds the read-port mux trees whose outputs drive the ALU operand path.
- Sits directly upstream of the 16:1/32:1 bit-slice mux tree, which consumes its register storage bits.
- XZR (X31) is hardwired to zero.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/mux16_1.sv | 10 +
 rtl/mux2_1.sv | 11 +
 rtl/mux32_1.sv | 15 +
 rtl/regfile_32x64.sv | 71 +++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 integer register file.
package regfile_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int NUM_PHYS   = 31;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

endpackage

// File: rtl/mux16_1.sv
// Single-bit 16:1 selector.
module mux16_1 (
  input  logic [15:0] d_i,
  input  logic [3:0]  sel_i,
  output logic        y_o
);

  assign y_o = d_i[sel_i];

endmodule

// File: rtl/mux2_1.sv
// Single-bit 2:1 selector.
module mux2_1 (
  input  logic d0_i,
  input  logic d1_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux32_1.sv
// Single-bit 32:1 selector: two 16:1 halves on sel[3:0], a 2:1 on sel[4].
module mux32_1 (
  input  logic [31:0] d_i,
  input  logic [4:0]  sel_i,
  output logic        y_o
);

  logic lo;
  logic hi;

  mux16_1 u_lo (.d_i(d_i[15:0]),  .sel_i(sel_i[3:0]), .y_o(lo));
  mux16_1 u_hi (.d_i(d_i[31:16]), .sel_i(sel_i[3:0]), .y_o(hi));
  mux2_1  u_top (.d0_i(lo), .d1_i(hi), .sel_i(sel_i[4]), .y_o(y_o));

endmodule

// File: rtl/regfile_32x64.sv
// 32x64 register file, one write port, two combinational read ports; X31 reads 0.
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2
);

  logic [NUM_REGS-1:0] wr_dec;
  reg_data_t           regs_q [NUM_PHYS];
  reg_data_t           regs_d [NUM_PHYS];
  reg_data_t           tree1;
  reg_data_t           tree2;

  // Decode only indexes with wr_addr when enabled, so X on an idle address cannot reach state.
  always_comb begin
    wr_dec = '0;
    if (wr_en) begin
      wr_dec[wr_addr] = 1'b1;
    end
    wr_dec[ZERO_REG] = 1'b0;
  end

  for (genvar r = 0; r < NUM_PHYS; r++) begin : g_reg
    assign regs_d[r] = wr_dec[r] ? wr_data : regs_q[r];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        regs_q[r] <= '0;
      end else begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [NUM_REGS-1:0] col;

    for (genvar r = 0; r < NUM_PHYS; r++) begin : g_col
      assign col[r] = regs_q[r][b];
    end
    assign col[ZERO_REG] = 1'b0;

    mux32_1 u_rd1 (.d_i(col), .sel_i(rd_addr1), .y_o(tree1[b]));
    mux32_1 u_rd2 (.d_i(col), .sel_i(rd_addr2), .y_o(tree2[b]));
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Reset gates the forward so outputs stay 0 while reset is held.
  assign byp1 = reset_n && wr_en && (wr_addr == rd_addr1) && (wr_addr != ZERO_REG);
  assign byp2 = reset_n && wr_en && (wr_addr == rd_addr2) && (wr_addr != ZERO_REG);

  assign rd_data1 = byp1 ? wr_data : tree1;
  assign rd_data2 = byp2 ? wr_data : tree2;
`else
  assign rd_data1 = tree1;
  assign rd_data2 = tree2;
`endif

endmodule
